// File: rtl/apb_arb_master.sv
// Round-robin arbiter that shares one APB master port between NUM_REQ requesters.
// Runs the SETUP/ACCESS sequence, honours wait states and aborts stalled transfers after TIMEOUT cycles.
module apb_arb_master #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_q, state_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     grant_q, grant_d;

  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     pick_cand;
  logic                 timed_out;
  logic                 do_grant;

  // Scan starts just after the previous winner so every requester gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pick_cand = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!pick_found && req_valid[pick_cand]) begin
        pick_found = 1'b1;
        pick_idx   = pick_cand;
      end
    end
  end

  assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    wait_cnt_d  = wait_cnt_q;
    last_d      = last_q;
    grant_d     = grant_q;
    do_grant    = 1'b0;

    case (state_q)
      IDLE: do_grant = 1'b1;
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready || timed_out) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
          rsp_err_d   = pready ? pslverr : 1'b1;
          do_grant    = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing ACCESS can hand the bus straight to the next winner.
    if (do_grant) begin
      if (pick_found) begin
        state_d              = SETUP;
        psel_d               = 1'b1;
        penable_d            = 1'b0;
        pwrite_d             = req_write[pick_idx];
        paddr_d              = req_addr[pick_idx*ADDR_W +: ADDR_W];
        pwdata_d             = req_write[pick_idx] ? req_wdata[pick_idx*DATA_W +: DATA_W] : '0;
        req_ready_d[pick_idx] = 1'b1;
        last_d               = pick_idx;
        grant_d              = pick_idx;
        wait_cnt_d           = '0;
      end else begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
      last_q      <= LAST_RST;
      grant_q     <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      wait_cnt_q  <= wait_cnt_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Bench for apb_arb_master: transaction-level model checked every cycle, plus directed
// scenarios with hand-computed latencies, grant orders and response values.
module tb_apb_arb_master;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      pclk;
  logic                      presetn;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  apb_arb_master #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          idx;
    int          lat;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int   checks;
  int   errors;
  int   cyc;
  int   load_cyc [NUM_REQ];
  int   acc_n;
  int   s_wait;
  logic [31:0] s_rdata;
  logic        s_err;
  logic [31:0] last_pwdata;
  req_t q0 [$];
  req_t q1 [$];
  rsp_t rsp_log [$];
  int   grant_log [$];

  // Transaction-level expectations
  logic        m_busy;
  logic        m_setup;
  int          m_req;
  int          m_last;
  int          m_waits;
  logic        e_psel;
  logic        e_penable;
  logic        e_pwrite;
  logic [31:0] e_paddr;
  logic [31:0] e_pwdata;
  logic [NUM_REQ-1:0] e_ready;
  logic [NUM_REQ-1:0] e_rspv;
  logic [31:0] e_rdata;
  logic        e_err;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_busy = 1'b0; m_setup = 1'b0; m_req = 0; m_last = NUM_REQ - 1; m_waits = 0;
    e_psel = 1'b0; e_penable = 1'b0; e_pwrite = 1'b0; e_paddr = '0; e_pwdata = '0;
    e_ready = '0; e_rspv = '0; e_rdata = '0; e_err = 1'b0;
  endtask

  task automatic modelFinish(input logic [31:0] rdata, input logic err);
    e_rspv[m_req] = 1'b1;
    e_rdata = rdata;
    e_err   = err;
    m_busy  = 1'b0;
  endtask

  task automatic modelStep();
    int g;
    e_ready = '0;
    e_rspv  = '0;
    if (m_busy) begin
      if (m_setup) begin
        m_setup   = 1'b0;
        e_penable = 1'b1;
      end else if (pready) begin
        modelFinish(e_pwrite ? 32'h0 : prdata, pslverr);
      end else begin
        m_waits++;
        if (TIMEOUT != 0 && m_waits == TIMEOUT) modelFinish(32'h0, 1'b1);
      end
    end
    if (!m_busy) begin
      g = -1;
      for (int k = 1; k <= NUM_REQ; k++)
        if (g < 0 && req_valid[(m_last + k) % NUM_REQ]) g = (m_last + k) % NUM_REQ;
      if (g >= 0) begin
        m_busy = 1'b1; m_setup = 1'b1; m_req = g; m_last = g; m_waits = 0;
        e_psel = 1'b1; e_penable = 1'b0;
        e_pwrite = req_write[g];
        e_paddr  = req_addr[g*ADDR_W +: ADDR_W];
        e_pwdata = req_write[g] ? req_wdata[g*DATA_W +: DATA_W] : 32'h0;
        e_ready[g] = 1'b1;
      end else begin
        e_psel = 1'b0; e_penable = 1'b0;
      end
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge pclk or negedge presetn);
      if (!presetn) modelReset();
      else modelStep();
    end
  end

  // Compare DUT against the model on every falling edge
  initial begin
    forever begin
      @(negedge pclk);
      checkOutput("psel", psel, e_psel);
      checkOutput("penable", penable, e_penable);
      checkOutput("pwrite", pwrite, e_pwrite);
      checkOutput("paddr", paddr, e_paddr);
      if (e_psel) checkOutput("pwdata", pwdata, e_pwdata);
      checkOutput("req_ready", req_ready, e_ready);
      checkOutput("rsp_valid", rsp_valid, e_rspv);
      checkOutput("rsp_rdata", rsp_rdata, e_rdata);
      checkOutput("rsp_err", rsp_err, e_err);
    end
  end

  task automatic pushReq(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.write = w; r.addr = a; r.wdata = d;
    if (i == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask

  task automatic loadReq(input int i, input req_t r);
    req_valid[i] = 1'b1;
    req_write[i] = r.write;
    req_addr[i*ADDR_W +: ADDR_W]  = r.addr;
    req_wdata[i*DATA_W +: DATA_W] = r.wdata;
    load_cyc[i] = cyc;
  endtask

  // One cycle of requester and slave behaviour, observed and driven at the falling edge
  task automatic applyStimulus();
    rsp_t e;
    req_t r;
    @(negedge pclk);
    cyc++;
    if (psel) last_pwdata = pwdata;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) grant_log.push_back(i);
    if (rsp_valid != '0) begin
      e.idx = rsp_valid[1] ? 1 : 0;
      e.lat = cyc - load_cyc[e.idx];
      e.cyc = cyc;
      e.rdata = rsp_rdata;
      e.err = rsp_err;
      rsp_log.push_back(e);
    end
    if (!presetn) begin
      req_valid = '0;
      pready = 1'b0;
      acc_n = 0;
    end else begin
      if (psel && penable) begin
        pready = (acc_n == s_wait);
        acc_n++;
      end else begin
        pready = 1'b0;
        acc_n = 0;
      end
      prdata  = s_rdata;
      pslverr = s_err;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i]) begin
          if (i == 0 && q0.size() > 0) begin
            r = q0.pop_front();
            loadReq(i, r);
          end else if (i == 1 && q1.size() > 0) begin
            r = q1.pop_front();
            loadReq(i, r);
          end
        end
      end
    end
  endtask

  task automatic runUntil(input int n, input int budget);
    int k;
    k = 0;
    while (rsp_log.size() < n && k < budget) begin
      applyStimulus();
      k++;
    end
    checkOutput("rsp_count", rsp_log.size(), n);
  endtask

  task automatic checkRsp(input string tag, input int pos, input int idx, input int lat,
                          input logic [31:0] rdata, input logic err);
    if (rsp_log.size() > pos) begin
      checkOutput({tag, "_idx"}, rsp_log[pos].idx, idx);
      checkOutput({tag, "_lat"}, rsp_log[pos].lat, lat);
      checkOutput({tag, "_rdata"}, rsp_log[pos].rdata, rdata);
      checkOutput({tag, "_err"}, rsp_log[pos].err, err);
    end
  endtask

  initial begin
    int n;
    int g0;
    int k;
    checks = 0; errors = 0; cyc = 0; acc_n = 0;
    load_cyc[0] = 0; load_cyc[1] = 0;
    presetn = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    s_wait = 0; s_rdata = '0; s_err = 1'b0; last_pwdata = '1;

    repeat (3) @(negedge pclk);
    checkOutput("rst_psel", psel, 0);
    checkOutput("rst_penable", penable, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_rsp", rsp_valid, 0);
    checkOutput("rst_paddr", paddr, 0);
    presetn = 1'b1;
    repeat (2) applyStimulus();

    $display("[TB] T1 single write, zero wait");
    s_wait = 0; s_err = 1'b0; s_rdata = 32'hFFFF_0000;
    n = rsp_log.size();
    pushReq(0, 1'b1, 32'h10, 32'hA5A5);
    runUntil(n + 1, 50);
    checkRsp("t1", n, 0, 3, 32'h0, 1'b0);

    $display("[TB] T2 read with three wait states");
    s_wait = 3; s_rdata = 32'h1234;
    n = rsp_log.size();
    pushReq(1, 1'b0, 32'h20, 32'hBEEF);
    runUntil(n + 1, 50);
    checkRsp("t2", n, 1, 6, 32'h1234, 1'b0);
    checkOutput("t2_pwdata", last_pwdata, 0);

    $display("[TB] T3 continuous contention");
    s_wait = 0; s_rdata = 32'h77;
    n = rsp_log.size();
    g0 = grant_log.size();
    pushReq(0, 1'b1, 32'h100, 32'h1);
    pushReq(0, 1'b1, 32'h104, 32'h2);
    pushReq(1, 1'b1, 32'h200, 32'h3);
    pushReq(1, 1'b1, 32'h204, 32'h4);
    runUntil(n + 4, 100);
    for (int j = 0; j < 4; j++) begin
      if (grant_log.size() > g0 + j) checkOutput("t3_grant", grant_log[g0 + j], j % 2);
      if (rsp_log.size() > n + j) checkOutput("t3_rsp_idx", rsp_log[n + j].idx, j % 2);
      if (j > 0 && rsp_log.size() > n + j)
        checkOutput("t3_gap", rsp_log[n + j].cyc - rsp_log[n + j - 1].cyc, 2);
    end

    $display("[TB] T4 slave error then clean read");
    s_err = 1'b1; s_wait = 0;
    n = rsp_log.size();
    pushReq(0, 1'b1, 32'h40, 32'h55);
    runUntil(n + 1, 50);
    checkRsp("t4a", n, 0, 3, 32'h0, 1'b1);
    s_err = 1'b0; s_rdata = 32'h5678;
    pushReq(1, 1'b0, 32'h44, 32'h0);
    runUntil(n + 2, 50);
    checkRsp("t4b", n + 1, 1, 3, 32'h5678, 1'b0);

    $display("[TB] T5 timeout abort");
    s_wait = 1000; s_rdata = 32'hDEAD;
    n = rsp_log.size();
    pushReq(0, 1'b0, 32'h30, 32'h0);
    runUntil(n + 1, 60);
    checkRsp("t5", n, 0, 18, 32'h0, 1'b1);
    s_wait = 0;
    repeat (2) applyStimulus();

    $display("[TB] T6 reset during ACCESS");
    s_wait = 5; s_rdata = 32'h9999;
    pushReq(0, 1'b0, 32'h50, 32'h0);
    k = 0;
    while (!(psel && penable) && k < 20) begin
      applyStimulus();
      k++;
    end
    checkOutput("t6_access", {psel, penable}, 2'b11);
    #2 presetn = 1'b0;
    #1;
    checkOutput("t6_psel", psel, 0);
    checkOutput("t6_penable", penable, 0);
    n = rsp_log.size();
    repeat (3) applyStimulus();
    presetn = 1'b1;
    repeat (2) applyStimulus();
    checkOutput("t6_norsp", rsp_log.size(), n);
    s_wait = 0;
    g0 = grant_log.size();
    pushReq(1, 1'b1, 32'h60, 32'h6);
    pushReq(0, 1'b1, 32'h70, 32'h7);
    runUntil(n + 2, 50);
    if (grant_log.size() > g0) checkOutput("t6_first", grant_log[g0], 0);
    if (grant_log.size() > g0 + 1) checkOutput("t6_second", grant_log[g0 + 1], 1);
    repeat (3) applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
